// File: rtl/rr_stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_stream_mux_pkg
//
// Purpose : Shared constants and helpers for the round-robin stream mux.
//           - clog2()        : constant function used to size channel indices.
//           - DEFAULT_DATA_W : default channel data width.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package rr_stream_mux_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Index width for 'value' items. A single item still gets one bit so
    // that index ports never collapse to zero width.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage : rr_stream_mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purpose : Round-robin request arbiter. Grants the first asserted request
//           found when searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
//           After a granted transfer, ptr moves to one past the winner with
//           an explicit wrap, so any N_CH (not only powers of two) is correct.
//
// Build option:
//   RR_STREAM_MUX_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins
//                                            (ptr is held at constant 0).
//   RR_STREAM_MUX_FIXED_PRIO_EN undefined -> round-robin (default).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (ptr -> 0)
//   req      in   [N_CH]  per-channel requests
//   advance  in   1 when the current grant is consumed this cycle
//   gnt_idx  out  [SEL_W] index of the granted channel (combinational)
//   gnt_vld  out  1 when any request is asserted (combinational)
// -----------------------------------------------------------------------------
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    localparam int SEL_W = clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic             found;
    int               idx;

    assign gnt_vld = |req;

    // Rotating priority search starting at ptr.
    // NOTE: every signal written in this always_comb gets a default at the
    // top; otherwise paths that skip an assignment would infer latches.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < N_CH; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
    // Fixed priority: the search always starts at channel 0.
    assign ptr_next = '0;
`else
    // Explicit wrap keeps non-power-of-two channel counts in range.
    assign ptr_next = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
`endif

    // ptr only moves on a completed transfer; idle cycles and stalls hold it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule : rr_arbiter

// File: rtl/rr_stream_mux.sv
// -----------------------------------------------------------------------------
// rr_stream_mux
//
// Purpose : Merges N_CH valid/ready input streams onto one registered output
//           stream using round-robin arbitration (see rr_arbiter). One word per
//           cycle when the consumer keeps out_ready high; a consume and a new
//           load may happen on the same edge, so there are no bubbles.
//
// Build option: RR_STREAM_MUX_FIXED_PRIO_EN selects fixed priority (lowest
//           asserted channel wins) inside rr_arbiter. Ports are identical in
//           both builds.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   [N_CH*DATA_W] channel i at [i*DATA_W +: DATA_W]
//   in_valid   in   [N_CH] per-channel valid
//   in_ready   out  [N_CH] per-channel ready (combinational, one-hot or zero)
//   out_data   out  [DATA_W] registered selected word
//   out_sel    out  [SEL_W] registered index of the channel behind out_data
//   out_valid  out  registered output valid
//   out_ready  in   consumer ready
// -----------------------------------------------------------------------------
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int SEL_W  = clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic              load_en;
    logic              xfer;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [DATA_W-1:0] sel_data;

    // The output register can take a word when it is empty or being drained.
    assign load_en = !out_valid || out_ready;

    // The granted channel always has in_valid set, so this is the handshake.
    assign xfer = load_en && gnt_vld;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (xfer),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // Output register. When nothing is valid the word and index keep their
    // last value; only out_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_sel   <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : rr_stream_mux

// File: tb/tb_rr_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_mux
//
// Directed bench for rr_stream_mux in its default (round-robin) build.
// Two instances: N_CH=8 for the main scenarios and N_CH=5 for the
// non-power-of-two wrap. Channel i of the 8-way instance carries 8'hA0+i
// unless a sequence overrides it; channel i of the 5-way one carries 8'h10+i.
// -----------------------------------------------------------------------------
module tb_rr_stream_mux;

    logic clk;
    logic rst;

    // 8-channel instance
    logic [7:0]  ch_data [8];
    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  in_ready8;
    logic [7:0]  out_data8;
    logic [2:0]  out_sel8;
    logic        out_valid8;
    logic        out_ready8;

    // 5-channel instance
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic [2:0]  out_sel5;
    logic        out_valid5;
    logic        out_ready5;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0] valid;
        logic       rdy;
        logic [7:0] exp_ready;
        logic       exp_ov;
        logic [2:0] exp_sel;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            in_data8[i*8 +: 8] = ch_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            in_data5[i*8 +: 8] = 8'h10 + 8'(i);
        end
    end

    rr_stream_mux #(.N_CH(8), .DATA_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_sel   (out_sel8),
        .out_valid (out_valid8),
        .out_ready (out_ready8)
    );

    rr_stream_mux #(.N_CH(5), .DATA_W(8)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_sel   (out_sel5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] valid, input logic rdy,
                                input logic [7:0] exp_ready, input logic exp_ov,
                                input logic [2:0] exp_sel, input logic [7:0] exp_data);
        vec_t v;
        v.valid     = valid;
        v.rdy       = rdy;
        v.exp_ready = exp_ready;
        v.exp_ov    = exp_ov;
        v.exp_sel   = exp_sel;
        v.exp_data  = exp_data;
        return v;
    endfunction

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // All channels valid, consumer always ready: grants 0..7,0,1.
        vecs[0]  = mk(8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        vecs[1]  = mk(8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1);
        vecs[2]  = mk(8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 8'hA2);
        vecs[3]  = mk(8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA3);
        vecs[4]  = mk(8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 8'hA4);
        vecs[5]  = mk(8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5);
        vecs[6]  = mk(8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 8'hA6);
        vecs[7]  = mk(8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 8'hA7);
        vecs[8]  = mk(8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 8'hA0);
        vecs[9]  = mk(8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 8'hA1);
        // ptr=2: only ch3 valid -> grant 3, ptr becomes 4.
        vecs[10] = mk(8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA3);
        // ch3+ch5 valid from ptr=4: 5, then 3, then 5.
        vecs[11] = mk(8'h28, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5);
        vecs[12] = mk(8'h28, 1'b1, 8'h08, 1'b1, 3'd3, 8'hA3);
        vecs[13] = mk(8'h28, 1'b1, 8'h20, 1'b1, 3'd5, 8'hA5);
        // Idle with ready: valid drops, word and index hold, ptr stays 6.
        vecs[14] = mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 8'hA5);

        for (int i = 0; i < 8; i++) ch_data[i] = 8'hA0 + 8'(i);
        in_valid8  = '0;
        out_ready8 = 1'b1;
        in_valid5  = '0;
        out_ready5 = 1'b1;

        // ---------------- reset ----------------
        rst = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid8), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("idle_out_valid", 64'(out_valid8), 64'd0);
            check("idle_out_sel",   64'(out_sel8),   64'd0);
            check("idle_in_ready",  64'(in_ready8),  64'd0);
        end

        // ---------------- vector table ----------------
        for (int i = 0; i < 15; i++) begin
            in_valid8  = vecs[i].valid;
            out_ready8 = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready8), 64'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid8), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_sel", i),   64'(out_sel8),   64'(vecs[i].exp_sel));
            check($sformatf("vec%0d_out_data", i),  64'(out_data8),  64'(vecs[i].exp_data));
        end

        // ---------------- stall with 8'h55, ptr=6 ----------------
        ch_data[6] = 8'h55;
        in_valid8  = 8'h40;
        out_ready8 = 1'b1;
        #1;
        check("load55_in_ready", 64'(in_ready8), 64'h40);
        tick();
        check("load55_out_data", 64'(out_data8), 64'h55);
        check("load55_out_sel",  64'(out_sel8),  64'd6);
        ch_data[6] = 8'hA6;
        in_valid8  = 8'hFF;
        out_ready8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("stall_in_ready", 64'(in_ready8), 64'd0);
            tick();
            check("stall_out_valid", 64'(out_valid8), 64'd1);
            check("stall_out_data",  64'(out_data8),  64'h55);
            check("stall_out_sel",   64'(out_sel8),   64'd6);
        end
        // Release: ptr must still be 7; consume and load on the same edge.
        out_ready8 = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready8), 64'h80);
        tick();
        check("release_out_valid", 64'(out_valid8), 64'd1);
        check("release_out_sel",   64'(out_sel8),   64'd7);
        check("release_out_data",  64'(out_data8),  64'hA7);

        // ---------------- reset during a stall ----------------
        ch_data[1] = 8'h55;
        in_valid8  = 8'h02;
        tick();
        check("pre_rst_out_data", 64'(out_data8), 64'h55);
        check("pre_rst_out_sel",  64'(out_sel8),  64'd1);
        in_valid8  = 8'hFF;
        out_ready8 = 1'b0;
        tick();
        check("pre_rst_stall_valid", 64'(out_valid8), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid8), 64'd0);
        check("async_rst_out_data",  64'(out_data8),  64'd0);
        check("async_rst_out_sel",   64'(out_sel8),   64'd0);
        @(negedge clk);
        rst        = 1'b0;
        ch_data[1] = 8'hA1;
        out_ready8 = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready8), 64'h01);
        tick();
        check("post_rst_out_sel",  64'(out_sel8),  64'd0);
        check("post_rst_out_data", 64'(out_data8), 64'hA0);
        in_valid8 = '0;

        // ---------------- N_CH=5 wrap ----------------
        in_valid5  = 5'h1F;
        out_ready5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("n5_step%0d_in_ready", k), 64'(in_ready5), 64'(5'd1 << (k % 5)));
            tick();
            check($sformatf("n5_step%0d_out_valid", k), 64'(out_valid5), 64'd1);
            check($sformatf("n5_step%0d_out_sel", k),   64'(out_sel5),   64'(k % 5));
            check($sformatf("n5_step%0d_out_data", k),  64'(out_data5),  64'(8'h10 + 8'(k % 5)));
        end
        in_valid5 = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rr_stream_mux
